// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port: picks between the execute
// unit and the load-return path, and runs a sequencer that clears x1..x31.
module regfile_wb_arbiter #(
   parameter logic        RR_EN     = 1'b1,
   parameter logic [31:0] CLR_VALUE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_ex_valid,
   input  logic [4:0]  i_ex_rd,
   input  logic [31:0] i_ex_data,
   output logic        o_ex_ready,
   input  logic        i_ld_valid,
   input  logic [4:0]  i_ld_rd,
   input  logic [31:0] i_ld_data,
   output logic        o_ld_ready,
   input  logic        i_clr_start,
   output logic        o_clr_busy,
   output logic        o_clr_done,
   output logic        o_we,
   output logic [4:0]  o_rw,
   output logic [31:0] o_busw
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t      r_state;
   logic [4:0]  r_idx;
   logic        r_ptr_ld;
   logic        r_we;
   logic [4:0]  r_rw;
   logic [31:0] r_busw;
   logic        r_clr_busy;
   logic        r_clr_done;

   logic        w_ex_ready;
   logic        w_ld_ready;
   logic        w_both;
   logic [4:0]  w_sel_rd;
   logic [31:0] w_sel_data;

   assign w_both = i_ex_valid && i_ld_valid;

   // Grant decode; a pending clear start blocks both requesters.
   always_comb begin
      w_ex_ready = 1'b0;
      w_ld_ready = 1'b0;
      if ((r_state == S_IDLE) && !i_clr_start) begin
         if (w_both) begin
            if ((RR_EN == 1'b1) && !r_ptr_ld) begin
               w_ex_ready = 1'b1;
            end else begin
               w_ld_ready = 1'b1;
            end
         end else if (i_ex_valid) begin
            w_ex_ready = 1'b1;
         end else if (i_ld_valid) begin
            w_ld_ready = 1'b1;
         end else begin
            w_ex_ready = 1'b0;
         end
      end else begin
         w_ex_ready = 1'b0;
      end
   end

   // Mux of the granted request onto the write path.
   always_comb begin
      if (w_ex_ready) begin
         w_sel_rd   = i_ex_rd;
         w_sel_data = i_ex_data;
      end else begin
         w_sel_rd   = i_ld_rd;
         w_sel_data = i_ld_data;
      end
   end

   // Controller state, round-robin pointer and registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_idx      <= 5'd1;
         r_ptr_ld   <= 1'b0;
         r_we       <= 1'b0;
         r_rw       <= 5'd0;
         r_busw     <= 32'h0000_0000;
         r_clr_busy <= 1'b0;
         r_clr_done <= 1'b0;
      end else begin
         r_we       <= 1'b0;
         r_clr_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_clr_start) begin
                  r_state    <= S_CLEAR;
                  r_idx      <= 5'd1;
                  r_clr_busy <= 1'b1;
               end else if (w_ex_ready || w_ld_ready) begin
                  // x0 writes are consumed but never reach the register file.
                  if (w_sel_rd != 5'd0) begin
                     r_we   <= 1'b1;
                     r_rw   <= w_sel_rd;
                     r_busw <= w_sel_data;
                  end
                  if (w_both) begin
                     r_ptr_ld <= ~r_ptr_ld;
                  end
               end
            end
            S_CLEAR: begin
               r_we   <= 1'b1;
               r_rw   <= r_idx;
               r_busw <= CLR_VALUE;
               if (r_idx == 5'd31) begin
                  r_state    <= S_IDLE;
                  r_idx      <= 5'd1;
                  r_clr_busy <= 1'b0;
                  r_clr_done <= 1'b1;
               end else begin
                  r_idx <= r_idx + 5'd1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_idx      <= 5'd1;
               r_clr_busy <= 1'b0;
            end
         endcase
      end
   end

   assign o_ex_ready = w_ex_ready;
   assign o_ld_ready = w_ld_ready;
   assign o_clr_busy = r_clr_busy;
   assign o_clr_done = r_clr_done;
   assign o_we       = r_we;
   assign o_rw       = r_rw;
   assign o_busw     = r_busw;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a round-robin instance and a
// fixed-priority instance share the same stimulus.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_data;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        clr_start;

   logic        ex_ready, ld_ready, clr_busy, clr_done, we;
   logic [4:0]  rw;
   logic [31:0] busw;
   logic        fp_ex_ready, fp_ld_ready, fp_clr_busy, fp_clr_done, fp_we;
   logic [4:0]  fp_rw;
   logic [31:0] fp_busw;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_arbiter #(.RR_EN(1'b1), .CLR_VALUE(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_data(ex_data), .o_ex_ready(ex_ready),
      .i_ld_valid(ld_valid), .i_ld_rd(ld_rd), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
      .i_clr_start(clr_start), .o_clr_busy(clr_busy), .o_clr_done(clr_done),
      .o_we(we), .o_rw(rw), .o_busw(busw)
   );

   regfile_wb_arbiter #(.RR_EN(1'b0), .CLR_VALUE(32'h0000_0000)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_data(ex_data), .o_ex_ready(fp_ex_ready),
      .i_ld_valid(ld_valid), .i_ld_rd(ld_rd), .i_ld_data(ld_data), .o_ld_ready(fp_ld_ready),
      .i_clr_start(clr_start), .o_clr_busy(fp_clr_busy), .o_clr_done(fp_clr_done),
      .o_we(fp_we), .o_rw(fp_rw), .o_busw(fp_busw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_ex;
      rst_n     = 1'b0;
      ex_valid  = 1'b0; ex_rd = 5'd0; ex_data = 32'h0;
      ld_valid  = 1'b0; ld_rd = 5'd0; ld_data = 32'h0;
      clr_start = 1'b0;
      tick(); tick();
      chk("rst_we", we, 32'd0);
      chk("rst_rw", rw, 32'd0);
      chk("rst_busw", busw, 32'd0);
      chk("rst_busy", clr_busy, 32'd0);
      chk("rst_done", clr_done, 32'd0);
      rst_n = 1'b1;

      // single ex request
      ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEAD_BEEF;
      #1;
      chk("t1_ex_ready", ex_ready, 32'd1);
      chk("t1_ld_ready", ld_ready, 32'd0);
      tick();
      ex_valid = 1'b0;
      chk("t1_we", we, 32'd1);
      chk("t1_rw", rw, 32'd5);
      chk("t1_busw", busw, 32'hDEAD_BEEF);
      tick();
      chk("t1_we_off", we, 32'd0);
      chk("t1_rw_hold", rw, 32'd5);

      // both valid: round-robin alternates, fixed priority always picks ld
      ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h0000_0011;
      ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h0000_0022;
      exp_ex = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t2_ex_ready", ex_ready, {31'd0, exp_ex});
         chk("t2_ld_ready", ld_ready, {31'd0, ~exp_ex});
         chk("t3_fp_ex_ready", fp_ex_ready, 32'd0);
         chk("t3_fp_ld_ready", fp_ld_ready, 32'd1);
         tick();
         chk("t2_we", we, 32'd1);
         chk("t2_rw", rw, exp_ex ? 32'd3 : 32'd4);
         chk("t2_busw", busw, exp_ex ? 32'h11 : 32'h22);
         chk("t3_fp_rw", fp_rw, 32'd4);
         chk("t3_fp_busw", fp_busw, 32'h22);
         exp_ex = ~exp_ex;
      end
      ex_valid = 1'b0; ld_valid = 1'b0;
      tick();

      // ld write to x0 is consumed but dropped
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF_FFFF;
      #1;
      chk("t4_ld_ready", ld_ready, 32'd1);
      tick();
      ld_valid = 1'b0;
      chk("t4_we_drop", we, 32'd0);
      ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 32'h1234_5678;
      #1;
      chk("t4_ex_ready", ex_ready, 32'd1);
      tick();
      ex_valid = 1'b0;
      chk("t4_we", we, 32'd1);
      chk("t4_rw", rw, 32'd1);
      chk("t4_busw", busw, 32'h1234_5678);

      // clear beats a same-cycle ex request
      clr_start = 1'b1;
      ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'h0000_0077;
      #1;
      chk("t5_ex_ready_blocked", ex_ready, 32'd0);
      chk("t5_ld_ready_blocked", ld_ready, 32'd0);
      tick();
      clr_start = 1'b0;
      chk("t5_busy_entry", clr_busy, 32'd1);
      chk("t5_we_entry", we, 32'd0);
      chk("t5_ex_ready_clear", ex_ready, 32'd0);
      for (int k = 1; k <= 31; k++) begin
         if (k == 15) clr_start = 1'b1;
         if (k == 16) clr_start = 1'b0;
         tick();
         chk("t5_we", we, 32'd1);
         chk("t5_rw", rw, k);
         chk("t5_busw", busw, 32'd0);
         chk("t5_done", clr_done, (k == 31) ? 32'd1 : 32'd0);
         chk("t5_busy", clr_busy, (k == 31) ? 32'd0 : 32'd1);
         chk("t5_ex_ready", ex_ready, (k == 31) ? 32'd1 : 32'd0);
      end
      tick();
      ex_valid = 1'b0;
      chk("t5_ex_we", we, 32'd1);
      chk("t5_ex_rw", rw, 32'd7);
      chk("t5_ex_busw", busw, 32'h77);
      chk("t5_done_off", clr_done, 32'd0);
      tick();

      // reset mid-clear
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      chk("t6_rw10", rw, 32'd10);
      chk("t6_busy_before", clr_busy, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_we_async", we, 32'd0);
      chk("t6_busy_async", clr_busy, 32'd0);
      chk("t6_done_async", clr_done, 32'd0);
      chk("t6_rw_async", rw, 32'd0);
      tick();
      rst_n = 1'b1;
      ex_valid = 1'b1; ex_rd = 5'd2; ex_data = 32'h0000_0002;
      #1;
      chk("t6_idle_ex_ready", ex_ready, 32'd1);
      tick();
      ex_valid = 1'b0;
      chk("t6_ex_rw", rw, 32'd2);
      tick();
      chk("t6_no_resume", we, 32'd0);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      tick();
      chk("t6_restart_we", we, 32'd1);
      chk("t6_restart_rw", rw, 32'd1);
      chk("t6_restart_busw", busw, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
